// File: rtl/req_arbiter.sv
// req_arbiter: two-port request arbiter with one forwarded master-side request.
// Both slave-side ports compete through a round-robin priority bit. The granted
// payload is registered onto the master side until the target accepts it. The
// source port of every accepted read is queued in an in-order tag FIFO, so the
// response router knows which port owns the oldest outstanding read. Reads are
// held off while that FIFO is full.
module req_arbiter #(
    parameter int AWIDTH    = 32,
    parameter int DWIDTH    = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              s0_req,
    input  logic              s0_cmd,
    input  logic [AWIDTH-1:0] s0_addr,
    input  logic [DWIDTH-1:0] s0_wdata,
    output logic              s0_ack,
    input  logic              s1_req,
    input  logic              s1_cmd,
    input  logic [AWIDTH-1:0] s1_addr,
    input  logic [DWIDTH-1:0] s1_wdata,
    output logic              s1_ack,
    output logic              m_req,
    output logic              m_cmd,
    output logic [AWIDTH-1:0] m_addr,
    output logic [DWIDTH-1:0] m_wdata,
    input  logic              m_ack,
    output logic              rd_tag_valid,
    output logic              rd_tag,
    input  logic              rd_tag_pop,
    output logic              tag_full
);

    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = $clog2(TAG_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_prio;
    logic                r_m_req;
    logic                r_m_cmd;
    logic [AWIDTH-1:0]   r_m_addr;
    logic [DWIDTH-1:0]   r_m_wdata;
    logic                r_s0_ack;
    logic                r_s1_ack;

    logic [TAG_DEPTH-1:0] r_tag_mem;
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;
    logic [CW-1:0]        r_count;

    logic w_tag_full;
    logic w_elig0;
    logic w_elig1;
    logic w_gnt0;
    logic w_gnt1;
    logic w_busy;
    logic w_push;
    logic w_push_tag;
    logic w_pop;

    // Pointer advance with explicit wrap at the FIFO depth.
    function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_tag_full = (r_count == CW'(TAG_DEPTH));

    // A read may only start if its tag is guaranteed a FIFO slot at acceptance;
    // with a single request in flight, "not full at grant" is sufficient.
    assign w_elig0 = s0_req & (s0_cmd | ~w_tag_full);
    assign w_elig1 = s1_req & (s1_cmd | ~w_tag_full);
    assign w_gnt0  = w_elig0 & (~w_elig1 | ~r_prio);
    assign w_gnt1  = w_elig1 & (~w_elig0 |  r_prio);

    assign w_busy     = (r_state == BUSY0) || (r_state == BUSY1);
    assign w_push     = w_busy & m_ack & ~r_m_cmd;
    assign w_push_tag = (r_state == BUSY1);
    assign w_pop      = rd_tag_pop & (r_count != '0);

    // Arbitration FSM: grant, hold the forwarded request until accepted, then
    // spend one ACK cycle so the requester can drop its request.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state   <= IDLE;
            r_prio    <= 1'b0;
            r_m_req   <= 1'b0;
            r_m_cmd   <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_s0_ack  <= 1'b0;
            r_s1_ack  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_s0_ack <= 1'b0;
                    r_s1_ack <= 1'b0;
                    if (w_gnt0) begin
                        r_state   <= BUSY0;
                        r_prio    <= 1'b1;
                        r_m_req   <= 1'b1;
                        r_m_cmd   <= s0_cmd;
                        r_m_addr  <= s0_addr;
                        r_m_wdata <= s0_wdata;
                    end else if (w_gnt1) begin
                        r_state   <= BUSY1;
                        r_prio    <= 1'b0;
                        r_m_req   <= 1'b1;
                        r_m_cmd   <= s1_cmd;
                        r_m_addr  <= s1_addr;
                        r_m_wdata <= s1_wdata;
                    end
                end
                BUSY0, BUSY1: begin
                    if (m_ack) begin
                        r_state   <= ACK;
                        r_m_req   <= 1'b0;
                        r_m_cmd   <= 1'b0;
                        r_m_addr  <= '0;
                        r_m_wdata <= '0;
                        r_s0_ack  <= (r_state == BUSY0);
                        r_s1_ack  <= (r_state == BUSY1);
                    end
                end
                ACK: begin
                    r_state  <= IDLE;
                    r_s0_ack <= 1'b0;
                    r_s1_ack <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Read-tag FIFO: push the source port of each accepted read, pop on request.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_tag_mem <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else begin
            if (w_push) begin
                r_tag_mem[r_wptr] <= w_push_tag;
                r_wptr            <= f_ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign m_req        = r_m_req;
    assign m_cmd        = r_m_cmd;
    assign m_addr       = r_m_addr;
    assign m_wdata      = r_m_wdata;
    assign s0_ack       = r_s0_ack;
    assign s1_ack       = r_s1_ack;
    assign rd_tag_valid = (r_count != '0);
    assign rd_tag       = r_tag_mem[r_rptr];
    assign tag_full     = w_tag_full;

endmodule

// File: tb/tb_req_arbiter.sv
// Testbench for req_arbiter: directed scenarios with hand-computed expectations
// plus a transaction-level reference model compared against the DUT every cycle.
module tb_req_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TD = 4;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          s0_req, s0_cmd, s0_ack;
    logic [AW-1:0] s0_addr;
    logic [DW-1:0] s0_wdata;
    logic          s1_req, s1_cmd, s1_ack;
    logic [AW-1:0] s1_addr;
    logic [DW-1:0] s1_wdata;
    logic          m_req, m_cmd, m_ack;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          rd_tag_valid, rd_tag, rd_tag_pop, tag_full;

    req_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .TAG_DEPTH(TD)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_req(s0_req), .s0_cmd(s0_cmd), .s0_addr(s0_addr), .s0_wdata(s0_wdata), .s0_ack(s0_ack),
        .s1_req(s1_req), .s1_cmd(s1_cmd), .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_ack(s1_ack),
        .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata), .m_ack(m_ack),
        .rd_tag_valid(rd_tag_valid), .rd_tag(rd_tag), .rd_tag_pop(rd_tag_pop), .tag_full(tag_full)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- requester / target agents ----------------
    typedef struct {
        bit          cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t q0[$];
    req_t q1[$];
    int   mack_delay = 0;
    bit   mack_en    = 1'b1;
    int   wcnt       = 0;
    int   cyc        = 0;
    int   ack0_cnt   = 0;
    int   ack1_cnt   = 0;
    int   mreq_cnt   = 0;
    bit   prev_mreq  = 1'b0;
    logic [31:0] glog[$];
    int   alog_port[$];
    int   alog_cyc[$];

    task automatic step();
        req_t tmp;
        @(posedge aclk);
        #1;
        cyc++;
        if (m_req) mreq_cnt++;
        if (m_req && !prev_mreq) glog.push_back(m_addr);
        prev_mreq = m_req;
        if (s0_ack) begin
            ack0_cnt++;
            alog_port.push_back(0);
            alog_cyc.push_back(cyc);
            if (q0.size() > 0) tmp = q0.pop_front();
        end
        if (s1_ack) begin
            ack1_cnt++;
            alog_port.push_back(1);
            alog_cyc.push_back(cyc);
            if (q1.size() > 0) tmp = q1.pop_front();
        end
        if (q0.size() > 0) begin
            s0_req = 1'b1; s0_cmd = q0[0].cmd; s0_addr = q0[0].addr; s0_wdata = q0[0].wdata;
        end else begin
            s0_req = 1'b0; s0_cmd = 1'b0; s0_addr = '0; s0_wdata = '0;
        end
        if (q1.size() > 0) begin
            s1_req = 1'b1; s1_cmd = q1[0].cmd; s1_addr = q1[0].addr; s1_wdata = q1[0].wdata;
        end else begin
            s1_req = 1'b0; s1_cmd = 1'b0; s1_addr = '0; s1_wdata = '0;
        end
        if (m_req && mack_en) begin
            m_ack = (wcnt >= mack_delay);
            wcnt++;
        end else begin
            m_ack = 1'b0;
            wcnt  = 0;
        end
    endtask

    task automatic clear_logs();
        ack0_cnt = 0; ack1_cnt = 0; mreq_cnt = 0;
        glog.delete(); alog_port.delete(); alog_cyc.delete();
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        q0.delete(); q1.delete();
        rd_tag_pop = 1'b0; mack_en = 1'b1; mack_delay = 0;
        step();
        step();
        aresetn = 1'b1;
        clear_logs();
    endtask

    task automatic wait_mreq(input string name);
        for (int i = 0; i < 20 && !m_req; i++) step();
        chk(name, m_req, 1'b1);
    endtask

    // ---------------- reference model ----------------
    // Transaction view: which port is in flight, which port is being acked,
    // the rotating priority and the queue of read owners.
    bit          model_on = 1'b0;
    int          mb       = -1;
    int          ma       = -1;
    int          mprio    = 0;
    bit          mb_cmd;
    logic [31:0] mb_addr, mb_wdata;
    bit          tq[$];
    bit          m_full, m_e0, m_e1, m_dummy;
    int          m_g;

    always @(posedge aclk) begin
        if (!aresetn) begin
            model_on = 1'b1;
            mb = -1; ma = -1; mprio = 0;
            tq.delete();
        end else if (model_on) begin
            m_full = (tq.size() == TD);
            if (rd_tag_pop && tq.size() > 0) m_dummy = tq.pop_front();
            if (mb >= 0) begin
                if (m_ack) begin
                    if (!mb_cmd) tq.push_back(mb[0]);
                    ma = mb;
                    mb = -1;
                end
            end else if (ma >= 0) begin
                ma = -1;
            end else begin
                m_e0 = s0_req && (s0_cmd || !m_full);
                m_e1 = s1_req && (s1_cmd || !m_full);
                m_g  = -1;
                if (m_e0 && m_e1) m_g = mprio;
                else if (m_e0)    m_g = 0;
                else if (m_e1)    m_g = 1;
                if (m_g >= 0) begin
                    mb       = m_g;
                    mb_cmd   = (m_g == 0) ? s0_cmd   : s1_cmd;
                    mb_addr  = (m_g == 0) ? s0_addr  : s1_addr;
                    mb_wdata = (m_g == 0) ? s0_wdata : s1_wdata;
                    mprio    = 1 - m_g;
                end
            end
        end
    end

    always @(negedge aclk) begin
        if (model_on) begin
            chk("mdl_m_req",   m_req,   mb >= 0);
            chk("mdl_m_cmd",   m_cmd,   (mb >= 0) ? mb_cmd   : 1'b0);
            chk("mdl_m_addr",  m_addr,  (mb >= 0) ? mb_addr  : 32'h0);
            chk("mdl_m_wdata", m_wdata, (mb >= 0) ? mb_wdata : 32'h0);
            chk("mdl_s0_ack",  s0_ack,  ma == 0);
            chk("mdl_s1_ack",  s1_ack,  ma == 1);
            chk("mdl_tag_valid", rd_tag_valid, tq.size() > 0);
            chk("mdl_tag_full",  tag_full,     tq.size() == TD);
            if (tq.size() > 0) chk("mdl_rd_tag", rd_tag, tq[0]);
        end
    end

    // ---------------- directed scenarios ----------------
    initial begin
        aresetn = 1'b0; rd_tag_pop = 1'b0; m_ack = 1'b0;
        s0_req = 1'b0; s0_cmd = 1'b0; s0_addr = '0; s0_wdata = '0;
        s1_req = 1'b0; s1_cmd = 1'b0; s1_addr = '0; s1_wdata = '0;
        step();
        step();
        chk("rst_m_req", m_req, 1'b0);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_s0_ack", s0_ack, 1'b0);
        chk("rst_tag_valid", rd_tag_valid, 1'b0);
        chk("rst_tag_full", tag_full, 1'b0);
        chk("rst_rd_tag", rd_tag, 1'b0);

        // Single read from s0, target accepts 2 cycles after m_req.
        do_reset();
        mack_delay = 2;
        q0.push_back('{1'b0, 32'h10, 32'h0});
        repeat (8) step();
        chk("rd1_mreq_cycles", mreq_cnt, 3);
        chk("rd1_s0_acks", ack0_cnt, 1);
        chk("rd1_grants", glog.size(), 1);
        if (glog.size() > 0) chk("rd1_addr", glog[0], 32'h10);
        chk("rd1_tag_valid", rd_tag_valid, 1'b1);
        chk("rd1_rd_tag", rd_tag, 1'b0);

        // Both ports request together: alternate, one accept every 3 cycles.
        do_reset();
        q0.push_back('{1'b1, 32'h100, 32'hA0}); q0.push_back('{1'b1, 32'h101, 32'hA1});
        q1.push_back('{1'b1, 32'h200, 32'hB0}); q1.push_back('{1'b1, 32'h201, 32'hB1});
        repeat (16) step();
        chk("rr_grants", glog.size(), 4);
        if (glog.size() >= 4) begin
            chk("rr_g0", glog[0], 32'h100);
            chk("rr_g1", glog[1], 32'h200);
            chk("rr_g2", glog[2], 32'h101);
            chk("rr_g3", glog[3], 32'h201);
        end
        chk("rr_acks", alog_port.size(), 4);
        if (alog_port.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("rr_ack_port", alog_port[i], i % 2);
            for (int i = 1; i < 4; i++) chk("rr_ack_gap", alog_cyc[i] - alog_cyc[i-1], 3);
        end

        // Tag FIFO full blocks reads but not writes; a pop releases the read.
        do_reset();
        for (int i = 0; i < 5; i++) q1.push_back('{1'b0, 32'h300 + i, 32'h0});
        repeat (15) step();
        chk("full_s1_acks", ack1_cnt, 4);
        chk("full_flag", tag_full, 1'b1);
        chk("full_rd_tag", rd_tag, 1'b1);
        q0.push_back('{1'b1, 32'h400, 32'h55});
        repeat (6) step();
        chk("full_wr_ack", ack0_cnt, 1);
        chk("full_s1_blocked", ack1_cnt, 4);
        rd_tag_pop = 1'b1;
        step();
        rd_tag_pop = 1'b0;
        repeat (6) step();
        chk("full_s1_after_pop", ack1_cnt, 5);
        chk("full_flag_again", tag_full, 1'b1);

        // Push and pop on the same edge with 2 entries queued.
        do_reset();
        q0.push_back('{1'b0, 32'h500, 32'h0});
        q1.push_back('{1'b0, 32'h600, 32'h0});
        repeat (8) step();
        chk("pp_head0", rd_tag, 1'b0);
        q0.push_back('{1'b0, 32'h501, 32'h0});
        wait_mreq("pp_wait_mreq");
        rd_tag_pop = 1'b1;
        step();
        rd_tag_pop = 1'b0;
        chk("pp_accept", s0_ack, 1'b1);
        chk("pp_head1", rd_tag, 1'b1);
        chk("pp_valid", rd_tag_valid, 1'b1);
        chk("pp_not_full", tag_full, 1'b0);
        rd_tag_pop = 1'b1;
        step();
        chk("pp_head2", rd_tag, 1'b0);
        chk("pp_valid2", rd_tag_valid, 1'b1);
        step();
        rd_tag_pop = 1'b0;
        chk("pp_empty", rd_tag_valid, 1'b0);

        // Reset while s1's request is waiting for the target.
        do_reset();
        q0.push_back('{1'b0, 32'h700, 32'h0});
        repeat (5) step();
        chk("rb_tag_before", rd_tag_valid, 1'b1);
        mack_en = 1'b0;
        q1.push_back('{1'b0, 32'h800, 32'h0});
        wait_mreq("rb_wait_mreq");
        chk("rb_busy_addr", m_addr, 32'h800);
        q0.push_back('{1'b1, 32'h701, 32'h0});
        aresetn = 1'b0;
        step();
        chk("rb_m_req", m_req, 1'b0);
        chk("rb_s1_ack", s1_ack, 1'b0);
        chk("rb_tag_valid", rd_tag_valid, 1'b0);
        chk("rb_tag_full", tag_full, 1'b0);
        chk("rb_rd_tag", rd_tag, 1'b0);
        clear_logs();
        prev_mreq = 1'b0;
        aresetn = 1'b1;
        mack_en = 1'b1;
        repeat (8) step();
        chk("rb_grants", glog.size(), 2);
        if (glog.size() >= 2) begin
            chk("rb_first_s0", glog[0], 32'h701);
            chk("rb_then_s1", glog[1], 32'h800);
        end
        chk("rb_s1_acks", ack1_cnt, 1);

        // Write from s1 carries data and leaves the tag FIFO alone.
        do_reset();
        q1.push_back('{1'b1, 32'h900, 32'hDEADBEEF});
        wait_mreq("wr_wait_mreq");
        chk("wr_cmd", m_cmd, 1'b1);
        chk("wr_wdata", m_wdata, 32'hDEADBEEF);
        chk("wr_addr", m_addr, 32'h900);
        repeat (4) step();
        chk("wr_ack", ack1_cnt, 1);
        chk("wr_no_tag", rd_tag_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/req_arbiter.md
REQ_ARBITER -- requirements
Module: req_arbiter

Interface
REQ-001 Parameter AWIDTH, default 32: address width of all request ports.
REQ-002 Parameter DWIDTH, default 32: write-data width of all request ports.
REQ-003 Parameter TAG_DEPTH, default 4 (power of 2): read-tag FIFO depth.
REQ-004 aclk  in  1  clock; all logic on rising edge.
REQ-005 aresetn  in  1  reset, synchronous, active-low.
REQ-006 sN_req  in  1  (N=0,1) request from slave-side port N; held until sN_ack.
REQ-007 sN_cmd  in  1  (N=0,1) 0=read, 1=write; stable while sN_req.
REQ-008 sN_addr  in  AWIDTH  (N=0,1) request address; stable while sN_req.
REQ-009 sN_wdata  in  DWIDTH  (N=0,1) write data; stable while sN_req.
REQ-010 sN_ack  out  1  (N=0,1) one-cycle acceptance pulse to port N.
REQ-011 m_req  out  1  forwarded request to master-side target.
REQ-012 m_cmd / m_addr / m_wdata  out  1 / AWIDTH / DWIDTH  forwarded payload.
REQ-013 m_ack  in  1  target acceptance; m_req considered accepted when m_ack=1 at clock edge while m_req=1.
REQ-014 rd_tag_valid  out  1  read-tag FIFO not empty.
REQ-015 rd_tag  out  1  source port id of oldest outstanding read.
REQ-016 rd_tag_pop  in  1  response router consumed rd_tag.
REQ-017 tag_full  out  1  read-tag FIFO holds TAG_DEPTH entries.

Function
REQ-018 FSM states IDLE, BUSY0, BUSY1, ACK; reset state IDLE.
REQ-019 Port N eligible when sN_req=1 and (sN_cmd=1 or tag_full=0).
REQ-020 IDLE: only one eligible -> grant it; both eligible -> grant port prio; none -> stay IDLE.
REQ-021 prio register, reset 0; on every grant prio <= complement of granted port id.
REQ-022 On grant: BUSYn next cycle, m_req<=1, m_cmd/m_addr/m_wdata <= granted port payload (registered, 1-cycle latency from sN_req to m_req).
REQ-023 BUSYn: m_req and payload held constant until m_ack=1; no timeout.
REQ-024 BUSYn with m_ack=1: m_req<=0, payload<=0, sn_ack<=1 for exactly one cycle, state -> ACK.
REQ-025 ACK: lasts exactly one cycle, no grant evaluated, -> IDLE (lets requester drop req; no double grant).
REQ-026 Accepted read (m_ack=1, m_cmd=0): push granted port id into tag FIFO at same edge.
REQ-027 Tag FIFO in-order; rd_tag shows head combinationally from FIFO storage; pop on rd_tag_pop & rd_tag_valid.
REQ-028 Simultaneous push and pop: both performed, count unchanged; pop when empty ignored; push never occurs when full (REQ-019).
REQ-029 Pointers wrap modulo TAG_DEPTH; count width log2(TAG_DEPTH)+1.
REQ-030 Write accepts never touch tag FIFO.
REQ-031 Minimum request throughput: one accept per 3 cycles (grant, m_ack same as first BUSY cycle, ACK).

Reset
REQ-032 aresetn=0 at any edge, including mid-BUSY: state IDLE, prio 0, m_req/m_cmd/m_addr/m_wdata 0, s0_ack/s1_ack 0, tag FIFO emptied (rd_tag_valid 0, tag_full 0, rd_tag 0).
REQ-033 In-flight request aborted by reset is not acked; requester re-arbitrates after reset release.

Verification
REQ-034 s0 read addr 0x10, m_ack 2 cycles after m_req -> m_req high 3 cycles, m_addr=0x10, s0_ack pulse 1 cycle, rd_tag_valid=1 rd_tag=0.
REQ-035 s0 and s1 req simultaneously from reset, m_ack immediate -> grant order s0, s1, s0, s1; each sN_ack single pulse, 3 cycles apart.
REQ-036 4 reads from s1 with no rd_tag_pop -> tag_full=1; 5th s1 read not granted while s0 write still granted; one pop -> 5th read granted.
REQ-037 Push and pop same cycle with 2 entries -> count stays 2, head advances to next tag.
REQ-038 aresetn=0 during BUSY1 -> next cycle m_req=0, no s1_ack, FIFO empty, prio=0.
REQ-039 s1 write wdata 0xDEADBEEF -> m_cmd=1, m_wdata=0xDEADBEEF, rd_tag_valid stays 0.
